// File: rtl/gearbox_132_128.sv
// ---------------------------------------------------------------------------
// gearbox_132_128
//
// Lossless, order-preserving width converter from a 132-bit input word
// stream to a 128-bit output word stream. 32 input words (4224 bits) map to
// exactly 33 output words. Bit 0 of every word is the oldest bit.
//
// Ports:
//   clk        in   1    single clock, all state updates on the rising edge
//   rst_n      in   1    asynchronous active-low reset
//   din        in   132  input word
//   din_valid  in   1    din carries a word this cycle
//   din_ready  out  1    block accepts din this cycle
//   dout       out  128  output word (always the 128 oldest buffered bits)
//   dout_valid out  1    dout holds a complete 128-bit word
//   dout_ready in   1    consumer takes dout this cycle
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high on that side. A producer holding valid keeps its
// data stable until ready; dout_valid never drops without a pop, and dout is
// stable while dout_valid=1 and dout_ready=0. din_ready may depend
// combinationally on dout_ready; dout/dout_valid never depend on din.
// ---------------------------------------------------------------------------
module gearbox_132_128 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [131:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [127:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready
);

  // Bit buffer: valid bits live in [C-1:0], oldest at bit 0. Bits at and
  // above C are always zero, so a new word can simply be OR-ed in.
  logic [255:0] bits_q, bits_d;
  // Fill count C stored as C/4 (C is always a multiple of 4, 0..256).
  logic [6:0]   cnt_q, cnt_d;

  logic         pop;
  logic         push;
  logic [255:0] base;
  logic [6:0]   off_w;
  logic [255:0] din_ext;

  assign dout_valid = (cnt_q >= 7'd32);
  assign dout       = bits_q[127:0];

  // Accept when the word fits as-is (C <= 124), or when a pop this same
  // cycle frees 128 bits and the result still fits (C <= 252).
  assign din_ready = (cnt_q <= 7'd31) ||
                     (dout_ready && (cnt_q >= 7'd32) && (cnt_q <= 7'd63));

  assign pop     = dout_valid && dout_ready;
  assign push    = din_valid && din_ready;
  assign din_ext = {124'b0, din};

  always_comb begin
    base   = bits_q;
    off_w  = cnt_q;
    bits_d = bits_q;
    cnt_d  = cnt_q;

    // When popping, the write position moves down with the shifted buffer.
    if (pop) begin
      base  = bits_q >> 128;
      off_w = cnt_q - 7'd32;
    end

    bits_d = base;
    if (push) begin
      bits_d = base | (din_ext << {off_w, 2'b00});
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 7'd33;  // +132 bits
      2'b01:   cnt_d = cnt_q - 7'd32;  // -128 bits
      2'b11:   cnt_d = cnt_q + 7'd1;   // +4 bits net
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gearbox_132_128.sv
// ---------------------------------------------------------------------------
// tb_gearbox_132_128
//
// Bench for gearbox_132_128. Accepted input words are appended to a bit-level
// model of the stream; every completed 128-bit word is queued as an expected
// output, and a monitor compares each word the DUT hands over. Directed
// checks cover reset, single-word, residue merge, throughput, backpressure
// and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_gearbox_132_128;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [131:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;

  always #5 clk = ~clk;

  gearbox_132_128 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  logic [511:0] acc_bits = '0;
  int           acc_n = 0;
  int           checks = 0;
  int           errors = 0;
  int           pops = 0;
  int           accepted = 0;
  int           k_word = 0;
  bit           gen_mode = 1'b0;

  logic [131:0] d0, d1, d2;
  logic [131:0] gw;
  logic [127:0] held;

  task automatic check(input string name, input logic [131:0] act,
                       input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [131:0] gen(input int k);
    logic [31:0] kk;
    kk = k;
    if (gen_mode == 1'b0) gen = {100'b0, kk};
    else                  gen = {kk[3:0], {4{kk ^ 32'hA5C3_0F1E}}};
  endfunction

  // Feeder: records every accepted input word into the bit model.
  always @(negedge clk) begin
    #1;
    if (rst_n && din_valid && din_ready) begin
      acc_bits = acc_bits | ({380'b0, din} << acc_n);
      acc_n    = acc_n + 132;
      while (acc_n >= 128) begin
        exp_q.push_back(acc_bits[127:0]);
        acc_bits = acc_bits >> 128;
        acc_n    = acc_n - 128;
      end
    end
  end

  // Monitor: compares every word the DUT hands over.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%h required=no_word", dout);
      end else begin
        check("stream_word", {4'b0, dout}, {4'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    acc_bits = '0;
    acc_n    = 0;
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, then releases.
  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    check({tag, "_rst_dout"}, {4'b0, dout}, 132'd0);
    check({tag, "_rst_dvalid"}, {131'b0, dout_valid}, 132'd0);
    check({tag, "_rst_dready"}, {131'b0, din_ready}, 132'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check({tag, "_post_dvalid"}, {131'b0, dout_valid}, 132'd0);
    check({tag, "_post_dready"}, {131'b0, din_ready}, 132'd1);
  endtask

  // Holds din_valid/dout_ready for n cycles; din advances on acceptance.
  task automatic run_cycles(input int n, input logic v, input logic r);
    bit ok;
    for (int i = 0; i < n; i++) begin
      din        = gen(k_word);
      din_valid  = v;
      dout_ready = r;
      @(negedge clk);
      ok = v && din_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        k_word++;
        accepted++;
      end
    end
    din_valid  = 1'b0;
    dout_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    d0 = 132'hA_0123456789ABCDEF_FEDCBA9876543210;
    d1 = 132'h3_13579BDF02468ACE_13579BDF02468ACE;
    d2 = 132'h6_0F0F0F0F11223344_55667788CAFEBABE;

    // Power-on reset.
    #1;
    check("por_dout", {4'b0, dout}, 132'd0);
    check("por_dvalid", {131'b0, dout_valid}, 132'd0);
    check("por_dready", {131'b0, din_ready}, 132'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("por_rel_dvalid", {131'b0, dout_valid}, 132'd0);
    check("por_rel_dready", {131'b0, din_ready}, 132'd1);

    // Single word.
    din = d0;
    din_valid = 1'b1;
    dout_ready = 1'b0;
    tick();
    din_valid = 1'b0;
    check("single_dvalid", {131'b0, dout_valid}, 132'd1);
    check("single_dout", {4'b0, dout}, {4'b0, d0[127:0]});
    check("single_dready", {131'b0, din_ready}, 132'd0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("single_pop_dvalid", {131'b0, dout_valid}, 132'd0);
    check("single_pop_dready", {131'b0, din_ready}, 132'd1);

    // Residue merge: 4 leftover bits of d0 precede d1.
    din = d1;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("residue_dvalid", {131'b0, dout_valid}, 132'd1);
    check("residue_dout", {4'b0, dout}, {4'b0, d1[123:0], 4'hA});
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    // Full-throughput stream.
    do_reset("tput");
    gen_mode = 1'b0;
    k_word = 0;
    accepted = 0;
    pops = 0;
    run_cycles(66, 1'b1, 1'b1);
    check("tput_accepted", 132'(accepted), 132'd64);
    run_cycles(4, 1'b0, 1'b1);
    check("tput_emitted", 132'(pops), 132'd66);
    check("tput_drained_dvalid", {131'b0, dout_valid}, 132'd0);
    check("tput_queue_empty", 132'(exp_q.size()), 132'd0);

    // Backpressure.
    do_reset("bp");
    gen_mode = 1'b1;
    k_word = 0;
    accepted = 0;
    pops = 0;
    run_cycles(1, 1'b1, 1'b0);
    gw = gen(0);
    held = gw[127:0];
    for (int i = 0; i < 10; i++) begin
      run_cycles(1, 1'b1, 1'b0);
      check("bp_dout_stable", {4'b0, dout}, {4'b0, held});
      check("bp_dvalid_stable", {131'b0, dout_valid}, 132'd1);
      check("bp_dready_low", {131'b0, din_ready}, 132'd0);
    end
    check("bp_accepted_one", 132'(accepted), 132'd1);
    run_cycles(12, 1'b1, 1'b1);
    run_cycles(4, 1'b0, 1'b1);
    check("bp_accepted", 132'(accepted), 132'd13);
    check("bp_emitted", 132'(pops), 132'd13);
    check("bp_queue_empty", 132'(exp_q.size()), 132'd0);

    // Mid-stream reset at C=136.
    do_reset("mid_pre");
    din = d0;
    din_valid = 1'b1;
    dout_ready = 1'b0;
    tick();
    din = d1;
    dout_ready = 1'b1;
    tick();
    din_valid = 1'b0;
    dout_ready = 1'b0;
    check("mid_c136_dout", {4'b0, dout}, {4'b0, d1[123:0], 4'hA});
    do_reset("mid");
    din = d2;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("mid_after_dvalid", {131'b0, dout_valid}, 132'd1);
    check("mid_after_dout", {4'b0, dout}, {4'b0, d2[127:0]});
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check("mid_after_pop_dvalid", {131'b0, dout_valid}, 132'd0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gearbox_132_128.md
Name: gearbox_132_128

Overview:
- Width converter: 132-bit input word stream to 128-bit output word stream, lossless and order-preserving.
- 32 input words (4224 bits) map exactly to 33 output words.
- Valid/ready handshake on both sides. Sits between a 132-bit datapath stage and a 128-bit consumer.

Parameters:
- None. Widths are fixed at 132 in and 128 out.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  132  input word; bit 0 is the oldest bit in the stream.
- din_valid  input  1  din carries a word this cycle.
- din_ready  output  1  block accepts din this cycle.
- dout  output  128  output word; bit 0 is the oldest bit.
- dout_valid  output  1  dout holds a complete 128-bit word.
- dout_ready  input  1  consumer takes dout this cycle.

Behaviour:
- State:
  - 256-bit bit buffer `buf`. Valid bits occupy [C-1:0]; the oldest bit is at bit 0.
  - Fill count C in 0..256, always a multiple of 4. Store it as C/4 in a 7-bit register.
- Reset (async, rst_n=0): C=0 and buf=0. Therefore dout_valid=0, dout=0 and din_ready=1 while in reset and after release.
- Outputs (combinational from registers and dout_ready):
  - dout_valid = (C >= 128).
  - dout = buf[127:0].
  - din_ready = (C <= 124) OR (dout_ready AND C >= 128 AND C <= 252).
  - din_ready has a combinational path from dout_ready. dout/dout_valid have no path from din.
- Transfers:
  - pop = dout_valid AND dout_ready.
  - push = din_valid AND din_ready.
- Per-cycle update:
  - Neither: hold.
  - pop only: buf shifts right by 128 (upper vacated bits zero); C = C-128.
  - push only: buf[C+131:C] = din; C = C+132.
  - pop and push: buf = (buf >> 128), then din is written at bit offset C-128; C = C+4.
- Capacity:
  - C never exceeds 256.
  - At C=256 din_ready=0 regardless of dout_ready. This is the one idle input cycle per 33 output cycles under full throughput.
  - With C in 128..252 and dout_ready=0, din_ready=0. Input is stalled and dout is held stable.
- Throughput: with din_valid=1 and dout_ready=1 continuously, the block accepts 32 words in every 33 cycles and emits 1 word per cycle once primed (after the first accepted word).
- din is ignored when din_valid=0 or din_ready=0. dout content is don't-care-free: it is always buf[127:0].
- dout_valid never drops without a pop. dout is stable while dout_valid=1 and dout_ready=0.
- Reset asserted mid-stream discards all buffered bits immediately. There is no partial-word flush.
- Single clock domain, no latches.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle.
  - Response: dout=0, dout_valid=0 and din_ready=1 immediately; remain so after release with din_valid=0.
- Single word:
  - Stimulus: after reset push D0=132'hA_0123456789ABCDEF_FEDCBA9876543210, with dout_ready=0.
  - Response: next cycle dout_valid=1, dout=D0[127:0], din_ready=0.
  - Then: dout_ready=1 for one cycle gives dout_valid=0 and C=4.
- Residue merge:
  - Stimulus: continuing from the single-word case, push D1.
  - Response: next cycle dout={D1[123:0], D0[131:128]}, dout_valid=1.
- Full-throughput stream:
  - Stimulus: din_valid=1 and dout_ready=1 for 66 cycles, input words = incrementing counter in bits [31:0], upper bits zero.
  - Response: exactly 64 words accepted and 66 words emitted (2 idle input cycles where C=256). The concatenated output bitstream equals the concatenated input bitstream.
- Backpressure:
  - Stimulus: din_valid=1, dout_ready=0.
  - Response: one word accepted, then din_ready=0. dout and dout_valid stay stable for 10 cycles. Releasing dout_ready resumes with no loss or duplication.
- Mid-stream reset:
  - Stimulus: pulse rst_n low at C=136.
  - Response: C=0, outputs cleared. The next pushed word appears unshifted at dout[127:0].
